rx78_psg: RTL and testbench

Write-only SN76489-compatible programmable sound generator on I/O port 0xFF of the RX-78 system. It receives the CPU's latch/data byte protocol, runs three square-wave tone channels and one LFSR noise channel from a clock enable, and emits an unsigned mixed audio sample. The top level decodes the port write into a one-cycle strobe. The top level also ties the `ready` output into the CPU wait logic when wait emulation is enabled.

---
 rtl/rx78_psg_pkg.sv | 42 ++++
 rtl/rx78_psg_tone.sv | 41 ++++
 rtl/rx78_psg.sv | 152 +++++++++++++++
 tb/tb_rx78_psg.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx78_psg_pkg.sv
// Shared constants for the RX-78 SN76489-compatible sound generator:
// volume table, register-select encodings, LFSR seed and noise divider reloads.
package rx78_psg_pkg;

    localparam int PRESC_W = 4;

    localparam logic [14:0] LFSR_SEED = 15'h4000;

    localparam logic [9:0] NOISE_RELOAD_0 = 10'h010;
    localparam logic [9:0] NOISE_RELOAD_1 = 10'h020;
    localparam logic [9:0] NOISE_RELOAD_2 = 10'h040;

    // 2 dB attenuation steps; index 15 is silence.
    localparam logic [12:0] VOL [16] = '{
        13'd8191, 13'd6506, 13'd5168, 13'd4105,
        13'd3261, 13'd2590, 13'd2057, 13'd1634,
        13'd1298, 13'd1031, 13'd819,  13'd650,
        13'd516,  13'd410,  13'd326,  13'd0
    };

    // sel[2:1] is the channel (3 = noise), sel[0] picks attenuation.
    typedef enum logic [2:0] {
        SEL_T0 = 3'd0,
        SEL_A0 = 3'd1,
        SEL_T1 = 3'd2,
        SEL_A1 = 3'd3,
        SEL_T2 = 3'd4,
        SEL_A2 = 3'd5,
        SEL_NC = 3'd6,
        SEL_A3 = 3'd7
    } sel_e;

    // Rate 3 follows channel 2, so its internal divider value is irrelevant.
    function automatic logic [9:0] noise_reload(input logic [1:0] rate);
        case (rate)
            2'd1:    return NOISE_RELOAD_1;
            2'd2:    return NOISE_RELOAD_2;
            default: return NOISE_RELOAD_0;
        endcase
    endfunction

endpackage

// File: rtl/rx78_psg_tone.sv
// Square-wave divider: 10-bit down counter that reloads and toggles q on each
// tick where it has reached 1 or below; periods 0 and 1 hold q high.
module rx78_psg_tone
    import rx78_psg_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       clr,
    input  logic [9:0] period,
    output logic       q
);

    logic [9:0] cnt;
    logic       hold;
    logic       expire;

    always_comb begin
        hold   = (period <= 10'd1);
        expire = tick && !clr && (cnt <= 10'd1);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= '0;
            q   <= 1'b0;
        end else begin
            if (clr) begin
                cnt <= '0;
            end else if (tick) begin
                cnt <= (cnt <= 10'd1) ? period : cnt - 10'd1;
            end
            if (hold) begin
                q <= 1'b1;
            end else if (expire) begin
                q <= ~q;
            end
        end
    end

endmodule

// File: rtl/rx78_psg.sv
// RX-78 port 0xFF sound generator: latch/data register file, prescaler, three
// tone channels, LFSR noise, busy timer and registered four-channel mixer.
module rx78_psg
    import rx78_psg_pkg::*;
#(
    parameter int READY_TICKS = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cen,
    input  logic        wr,
    input  logic [7:0]  din,
    output logic        ready,
    output logic [15:0] audio
);

    localparam int BW = $clog2(READY_TICKS + 1);

    sel_e               sel;
    sel_e               sel_w;
    logic [2:0]         sel_bits;
    logic [1:0]         ch_w;
    logic               noise_wr;
    logic [9:0]         period [3];
    logic [3:0]         att [4];
    logic [2:0]         ctrl;
    logic [PRESC_W-1:0] presc;
    logic               tick;
    logic [2:0]         tone_q;
    logic               noise_q;
    logic               q2_d;
    logic               qn_d;
    logic               shift;
    logic               fb;
    logic [14:0]        lfsr;
    logic [BW-1:0]      busy;
    logic [14:0]        mix;
    logic [15:0]        audio_p1;

    // A data byte reuses the stored select; a latch byte replaces it.
    always_comb begin
        sel_w    = din[7] ? sel_e'(din[6:4]) : sel;
        sel_bits = sel_w;
        ch_w     = sel_bits[2:1];
        noise_wr = wr && (sel_w == SEL_NC);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sel  <= SEL_T0;
            ctrl <= '0;
            for (int i = 0; i < 3; i++) period[i] <= '0;
            for (int i = 0; i < 4; i++) att[i] <= 4'hF;
        end else if (wr) begin
            sel <= sel_w;
            if (sel_bits[0]) begin
                att[ch_w] <= din[3:0];
            end else if (ch_w == 2'd3) begin
                ctrl <= din[2:0];
            end else if (din[7]) begin
                period[ch_w][3:0] <= din[3:0];
            end else begin
                period[ch_w][9:4] <= din[5:0];
            end
        end
    end

    always_comb tick = cen && (presc == '1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            presc <= '0;
        end else if (cen) begin
            presc <= presc + PRESC_W'(1);
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_tone
        rx78_psg_tone u_tone (
            .clk     (clk),
            .reset_n (reset_n),
            .tick    (tick),
            .clr     (1'b0),
            .period  (period[g]),
            .q       (tone_q[g])
        );
    end

    rx78_psg_tone u_noise_div (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick),
        .clr     (noise_wr),
        .period  (noise_reload(ctrl[1:0])),
        .q       (noise_q)
    );

    // Each source keeps its own history so switching rate never fakes an edge.
    always_comb begin
        shift = (ctrl[1:0] == 2'd3) ? (tone_q[2] & ~q2_d) : (noise_q & ~qn_d);
        fb    = ctrl[2] ? (lfsr[0] ^ lfsr[1]) : lfsr[0];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lfsr <= LFSR_SEED;
            q2_d <= 1'b0;
            qn_d <= 1'b0;
        end else begin
            q2_d <= tone_q[2];
            qn_d <= noise_q;
            if (noise_wr) begin
                lfsr <= LFSR_SEED;
            end else if (shift) begin
                lfsr <= {fb, lfsr[14:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ready <= 1'b1;
            busy  <= '0;
        end else if (wr) begin
            ready <= 1'b0;
            busy  <= BW'(READY_TICKS);
        end else if (cen && !ready) begin
            busy <= busy - BW'(1);
            if (busy == BW'(1)) ready <= 1'b1;
        end
    end

    always_comb begin
        mix = '0;
        for (int i = 0; i < 3; i++) begin
            if (tone_q[i]) mix = mix + {2'b00, VOL[att[i]]};
        end
        if (lfsr[0]) mix = mix + {2'b00, VOL[att[3]]};
    end

    // Stage p1: registered mix
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            audio_p1 <= '0;
        end else begin
            audio_p1 <= {1'b0, mix};
        end
    end

    assign audio = audio_p1;

endmodule

// File: tb/tb_rx78_psg.sv
// Bench for rx78_psg: directed scenarios plus random traffic, each cycle
// compared with a behavioural model of the register/tone/noise/busy rules.
module tb_rx78_psg;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cen = 1'b0;
    logic        wr = 1'b0;
    logic [7:0]  din = 8'h00;
    logic        ready;
    logic [15:0] audio;

    int total = 0;
    int bad = 0;

    rx78_psg #(.READY_TICKS(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .cen     (cen),
        .wr      (wr),
        .din     (din),
        .ready   (ready),
        .audio   (audio)
    );

    always #5 clk = ~clk;

    int vol_t [16] = '{8191, 6506, 5168, 4105, 3261, 2590, 2057, 1634,
                       1298, 1031, 819, 650, 516, 410, 326, 0};

    // Model state: index 0..2 tones, index 3 the noise rate divider.
    int m_per [3];
    int m_att [4];
    int m_cnt [4];
    int m_q [4];
    int m_ctrl, m_sel, m_lfsr, m_presc, m_prev2, m_prevn;
    int m_audio, m_ready, m_busy;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_per[i] = 0;
        for (int i = 0; i < 4; i++) begin
            m_att[i] = 15;
            m_cnt[i] = 0;
            m_q[i] = 0;
        end
        m_ctrl = 0; m_sel = 0; m_lfsr = 'h4000; m_presc = 0;
        m_prev2 = 0; m_prevn = 0; m_audio = 0; m_ready = 1; m_busy = 0;
    endtask

    task automatic model_step(input bit w, input int d, input bit c, input bit rn);
        int s, ch, nwr, tick, shift, mix, fb;
        int per_n [3];
        int att_n [4];
        int pers [4];
        int ctrl_n;
        if (!rn) begin
            model_reset();
            return;
        end
        per_n = m_per; att_n = m_att; ctrl_n = m_ctrl; nwr = 0; s = m_sel;
        if (w) begin
            if (d >= 128) s = (d / 16) % 8;
            ch = s / 2;
            if (s % 2 == 1) att_n[ch] = d % 16;
            else if (ch == 3) begin ctrl_n = d % 8; nwr = 1; end
            else if (d >= 128) per_n[ch] = (m_per[ch] / 16) * 16 + d % 16;
            else per_n[ch] = (d % 64) * 16 + m_per[ch] % 16;
        end
        mix = 0;
        for (int i = 0; i < 3; i++) if (m_q[i] != 0) mix += vol_t[m_att[i]];
        if (m_lfsr % 2 == 1) mix += vol_t[m_att[3]];
        shift = (m_ctrl % 4 == 3) ? (m_q[2] != 0 && m_prev2 == 0) : (m_q[3] != 0 && m_prevn == 0);
        m_prev2 = m_q[2];
        m_prevn = m_q[3];
        tick = c && (m_presc == 15);
        if (c) m_presc = (m_presc + 1) % 16;
        for (int i = 0; i < 3; i++) pers[i] = m_per[i];
        pers[3] = (m_ctrl % 4 == 3) ? 16 : (16 << (m_ctrl % 4));
        for (int i = 0; i < 4; i++) begin
            if (i == 3 && nwr != 0) m_cnt[3] = 0;
            else if (tick != 0) begin
                if (m_cnt[i] <= 1) begin
                    if (pers[i] > 1) m_q[i] = 1 - m_q[i];
                    m_cnt[i] = pers[i];
                end else m_cnt[i] = m_cnt[i] - 1;
            end
            if (pers[i] <= 1) m_q[i] = 1;
        end
        if (nwr != 0) m_lfsr = 'h4000;
        else if (shift != 0) begin
            fb = (m_ctrl >= 4) ? ((m_lfsr ^ (m_lfsr >> 1)) & 1) : (m_lfsr & 1);
            m_lfsr = (m_lfsr >> 1) | (fb << 14);
        end
        if (w) begin m_busy = 32; m_ready = 0; end
        else if (c && m_ready == 0) begin
            m_busy = m_busy - 1;
            if (m_busy == 0) m_ready = 1;
        end
        m_audio = mix;
        m_per = per_n; m_att = att_n; m_ctrl = ctrl_n; m_sel = s;
    endtask

    task automatic step(input bit w, input logic [7:0] d, input bit c, input bit rn);
        wr = w; din = d; cen = c; reset_n = rn;
        model_step(w, int'(d), c, rn);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 6; i++) begin
            step(i % 2 == 1, 8'h90, 1'b1, 1'b0);
            total++;
            if (audio !== 16'd0) begin bad++; $display("FAIL reset_audio got=%0d want=0", audio); end
            total++;
            if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ready); end
        end
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b1);
            total++;
            if (audio !== 16'd0) begin bad++; $display("FAIL reset_silent cyc=%0d got=%0d want=0", i, audio); end
        end
    endtask

    task automatic test_tone();
        int last, last_t, ntr;
        reset_dut();
        step(1'b1, 8'h80, 1'b1, 1'b1);
        step(1'b1, 8'h01, 1'b1, 1'b1);
        step(1'b1, 8'h90, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        last = int'(audio); last_t = -1; ntr = 0;
        for (int i = 0; i < 1200; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b1);
            total++;
            if (audio !== m_audio[15:0]) begin bad++; $display("FAIL tone_model cyc=%0d got=%0d want=%0d", i, audio, m_audio); end
            if (int'(audio) != last) begin
                if (last_t >= 0) begin
                    total++;
                    if (i - last_t != 256) begin bad++; $display("FAIL tone_interval got=%0d want=256", i - last_t); end
                end
                total++;
                if (audio !== 16'd0 && audio !== 16'd8191) begin bad++; $display("FAIL tone_level got=%0d want=0_or_8191", audio); end
                last = int'(audio); last_t = i; ntr++;
            end
        end
        total++;
        if (ntr < 4) begin bad++; $display("FAIL tone_toggles got=%0d want>=4", ntr); end
    endtask

    task automatic test_att_latch_data();
        reset_dut();
        step(1'b1, 8'hBF, 1'b1, 1'b1);
        step(1'b1, 8'h03, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b1, 1'b1);
        total++;
        if (audio !== 16'd4105) begin bad++; $display("FAIL att1_is_3 got=%0d want=4105", audio); end
        step(1'b1, 8'h22, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 600; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b1);
            total++;
            if (audio !== 16'd5168) begin bad++; $display("FAIL att1_is_2 cyc=%0d got=%0d want=5168", i, audio); end
        end
    endtask

    task automatic test_period_hold();
        reset_dut();
        step(1'b1, 8'hC1, 1'b1, 1'b1);
        step(1'b1, 8'h00, 1'b1, 1'b1);
        step(1'b1, 8'hD0, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 10000; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b1);
            total++;
            if (audio !== 16'd8191) begin bad++; $display("FAIL hold_steady cyc=%0d got=%0d want=8191", i, audio); end
        end
    endtask

    task automatic test_noise();
        int ones;
        reset_dut();
        step(1'b1, 8'hE4, 1'b1, 1'b1);
        step(1'b1, 8'hF0, 1'b1, 1'b1);
        ones = 0;
        for (int i = 0; i < 9000; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b1);
            total++;
            if (audio !== m_audio[15:0]) begin bad++; $display("FAIL noise_white cyc=%0d got=%0d want=%0d", i, audio, m_audio); end
            if (audio == 16'd8191) ones++;
        end
        total++;
        if (ones == 0) begin bad++; $display("FAIL noise_active got=%0d want>0", ones); end
        step(1'b1, 8'hC5, 1'b1, 1'b1);
        step(1'b1, 8'hE7, 1'b1, 1'b1);
        for (int i = 0; i < 6000; i++) begin
            step(1'b0, 8'h00, ($urandom % 3) != 0, 1'b1);
            total++;
            if (audio !== m_audio[15:0]) begin bad++; $display("FAIL noise_ch2 cyc=%0d got=%0d want=%0d", i, audio, m_audio); end
        end
    endtask

    task automatic test_busy();
        int n;
        bit c;
        reset_dut();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b1);
            total++;
            if (ready !== 1'b1) begin bad++; $display("FAIL busy_idle got=%b want=1", ready); end
        end
        step(1'b1, 8'h9F, 1'b0, 1'b1);
        total++;
        if (ready !== 1'b0) begin bad++; $display("FAIL busy_start got=%b want=0", ready); end
        n = 0;
        for (int i = 0; i < 80 && n < 34; i++) begin
            c = (i % 2 == 1);
            step(1'b0, 8'h00, c, 1'b1);
            if (c) n++;
            total++;
            if (ready !== (n >= 32)) begin bad++; $display("FAIL busy_count cen=%0d got=%b want=%b", n, ready, n >= 32); end
        end
        step(1'b1, 8'h9F, 1'b0, 1'b1);
        n = 0;
        for (int i = 0; n < 10; i++) begin
            c = (i % 2 == 1);
            step(1'b0, 8'h00, c, 1'b1);
            if (c) n++;
        end
        step(1'b1, 8'h9E, 1'b0, 1'b1);
        total++;
        if (ready !== 1'b0) begin bad++; $display("FAIL busy_restart got=%b want=0", ready); end
        n = 0;
        for (int i = 0; i < 80 && n < 34; i++) begin
            c = (i % 2 == 1);
            step(1'b0, 8'h00, c, 1'b1);
            if (c) n++;
            total++;
            if (ready !== (n >= 32)) begin bad++; $display("FAIL busy_overlap cen=%0d got=%b want=%b", n, ready, n >= 32); end
        end
        step(1'b1, 8'h9F, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        total++;
        if (ready !== 1'b1) begin bad++; $display("FAIL busy_reset got=%b want=1", ready); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [6] = '{8'h85, 8'h12, 8'h9A, 8'hA3, 8'h3F, 8'hB4};
        reset_dut();
        for (int i = 0; i < 6; i++) step(1'b1, seq[i], 1'b1, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b1);
            total++;
            if (audio !== m_audio[15:0]) begin bad++; $display("FAIL b2b_model cyc=%0d got=%0d want=%0d", i, audio, m_audio); end
        end
    endtask

    task automatic test_random();
        bit w, c, rn;
        logic [7:0] d;
        reset_dut();
        for (int i = 0; i < 20000; i++) begin
            w = ($urandom % 6) == 0;
            d = 8'($urandom);
            c = ($urandom % 2) == 0;
            rn = ($urandom % 4000) != 0;
            step(w, d, c, rn);
            total++;
            if (audio !== m_audio[15:0]) begin bad++; $display("FAIL rand_audio cyc=%0d got=%0d want=%0d", i, audio, m_audio); end
            total++;
            if (ready !== m_ready[0]) begin bad++; $display("FAIL rand_ready cyc=%0d got=%b want=%0d", i, ready, m_ready); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_tone();
        test_att_latch_data();
        test_period_hold();
        test_noise();
        test_busy();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
